dram_lsu: RTL and testbench

Load/store unit sitting between the core's MEM stage and the data memory (`RWMEM`). It acts as the initiator side of the DRAM ENABLE/READNOTWRITE/DATA_READY handshake. It converts RV32I load/store requests (byte, half, word; signed and unsigned) into word-wide memory transactions, and performs read-modify-write for sub-word stores because the memory has no byte enables. It stalls the core until each access completes.

---
 rtl/dram_lsu_pkg.sv | 40 ++++
 rtl/dram_lsu_if.sv | 41 ++++
 rtl/dram_lsu_align.sv | 50 +++++
 rtl/dram_lsu.sv | 181 ++++++++++++++++++
 tb/tb_dram_lsu.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_lsu_pkg.sv
// Shared types for the dram_lsu load/store unit: funct3 codes, FSM states, access size decode.
// Latency: none (types and pure functions only).
// Backpressure: n/a. Optional feature in dram_lsu is selected by macro LSU_TIMEOUT_EN.
package mytypes;

  localparam int numbit = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MERGE,
    S_WR,
    S_RESP
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_t;

  // Unsigned variants only exist for loads; any code not recognised is a word access.
  function automatic lsu_size_t f3_size(input logic we, input logic [2:0] f3);
    lsu_size_t sz;
    sz = SZ_W;
    if (f3 == F3_B || (!we && f3 == F3_BU)) begin
      sz = SZ_B;
    end else if (f3 == F3_H || (!we && f3 == F3_HU)) begin
      sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// Core-request and DRAM-handshake bundle for dram_lsu; slave = LSU side, master = core/memory side.
// Latency: wires only.
// Backpressure: core holds req_* while stall is high; memory completes with DRAM_READY.
interface dram_lsu_if #(
  parameter int NUMBIT    = mytypes::numbit,
  parameter int ADDR_SIZE = 32
);

  logic                 req_valid;
  logic                 req_we;
  logic [2:0]           req_funct3;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [NUMBIT-1:0]    req_wdata;
  logic [NUMBIT-1:0]    rdata;
  logic                 done;
  logic                 stall;
  logic                 misalign;
  logic                 timeout;

  logic                 DRAM_ENABLE;
  logic                 DRAM_READNOTWRITE;
  logic [ADDR_SIZE-1:0] DRAM_ADDRESS;
  logic [NUMBIT-1:0]    DRAM_IN;
  logic [NUMBIT-1:0]    DRAM_OUT;
  logic                 DRAM_READY;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output rdata, done, stall, misalign, timeout,
    output DRAM_ENABLE, DRAM_READNOTWRITE, DRAM_ADDRESS, DRAM_IN,
    input  DRAM_OUT, DRAM_READY
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  rdata, done, stall, misalign, timeout,
    input  DRAM_ENABLE, DRAM_READNOTWRITE, DRAM_ADDRESS, DRAM_IN,
    output DRAM_OUT, DRAM_READY
  );

endinterface

// File: rtl/dram_lsu_align.sv
// Lane steering: extracts a byte/half/word with sign or zero extension, and merges store data into a word.
// Latency: combinational.
// Backpressure: none.
module lsu_align
  import mytypes::*;
#(
  parameter int NUMBIT = numbit
) (
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        lane_i,
  input  logic [NUMBIT-1:0] ld_word_i,
  input  logic [NUMBIT-1:0] st_word_i,
  input  logic [15:0]       st_src_i,
  output logic [NUMBIT-1:0] ld_data_o,
  output logic [NUMBIT-1:0] st_data_o
);

  lsu_size_t  sz;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sign_en;

  assign sz      = f3_size(we_i, funct3_i);
  assign ld_byte = ld_word_i[{lane_i, 3'b000} +: 8];
  assign ld_half = ld_word_i[{lane_i[1], 4'b0000} +: 16];
  // funct3[2] marks the unsigned load variants
  assign sign_en = ~funct3_i[2];

  // Load path: pick the addressed lane and extend it to the full word
  always_comb begin
    ld_data_o = ld_word_i;
    case (sz)
      SZ_B:    ld_data_o = {{(NUMBIT-8){ld_byte[7] & sign_en}}, ld_byte};
      SZ_H:    ld_data_o = {{(NUMBIT-16){ld_half[15] & sign_en}}, ld_half};
      default: ld_data_o = ld_word_i;
    endcase
  end

  // Store path: overwrite only the addressed lane of the previously read word
  always_comb begin
    st_data_o = st_word_i;
    case (sz)
      SZ_B:    st_data_o[{lane_i, 3'b000} +: 8]     = st_src_i[7:0];
      SZ_H:    st_data_o[{lane_i[1], 4'b0000} +: 16] = st_src_i;
      default: st_data_o = st_word_i;
    endcase
  end

endmodule

// File: rtl/dram_lsu.sv
// RV32I load/store unit driving a word-wide DRAM handshake; sub-word stores use read-modify-write.
// Latency: zero-wait memory gives done 3 cycles after request (load/SW), 5 (SB/SH), 2 (misaligned).
// Backpressure: stall = req_valid & ~done; waits on DRAM_READY (bounded only with LSU_TIMEOUT_EN).
module dram_lsu
  import mytypes::*;
#(
  parameter int NUMBIT         = numbit,
  parameter int ADDR_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic      CLK,
  input  logic      RST,
  dram_lsu_if.slave bus
);

  lsu_state_t           state_q;
  logic                 enable_q;
  logic                 rnw_q;
  logic                 done_q;
  logic                 misalign_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [NUMBIT-1:0]    din_q;
  logic [NUMBIT-1:0]    word_q;
  logic [NUMBIT-1:0]    rdata_q;

  lsu_size_t            req_size;
  logic                 req_misalign;
  logic [NUMBIT-1:0]    ld_data_d;
  logic [NUMBIT-1:0]    merged_d;

  assign req_size     = f3_size(bus.req_we, bus.req_funct3);
  assign req_misalign = (req_size == SZ_H && bus.req_addr[0]) ||
                        (req_size == SZ_W && bus.req_addr[1:0] != 2'b00);

  // Load data is extended straight from DRAM_OUT; merge works on the captured word
  lsu_align #(.NUMBIT(NUMBIT)) u_align (
    .we_i      (bus.req_we),
    .funct3_i  (bus.req_funct3),
    .lane_i    (bus.req_addr[1:0]),
    .ld_word_i (bus.DRAM_OUT),
    .st_word_i (word_q),
    .st_src_i  (bus.req_wdata[15:0]),
    .ld_data_o (ld_data_d),
    .st_data_o (merged_d)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_q;
  logic             timeout_q;
  logic             wait_expired;
  assign wait_expired = (wait_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.timeout  = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign bus.timeout        = 1'b0;
`endif

  // Sequencer: all handshake outputs are registered so they are stable for the whole ENABLE window
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      enable_q   <= 1'b0;
      rnw_q      <= 1'b1;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q <= {bus.req_addr[ADDR_SIZE-1:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (req_misalign) begin
              state_q    <= S_RESP;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              rdata_q    <= '0;
            end else if (bus.req_we && req_size == SZ_W) begin
              state_q  <= S_WR;
              enable_q <= 1'b1;
              rnw_q    <= 1'b0;
              din_q    <= bus.req_wdata;
            end else begin
              state_q  <= S_RD;
              enable_q <= 1'b1;
              rnw_q    <= 1'b1;
            end
          end
        end
        S_RD: begin
          if (bus.DRAM_READY) begin
            enable_q <= 1'b0;
            word_q   <= bus.DRAM_OUT;
            if (bus.req_we) begin
              state_q <= S_MERGE;
            end else begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              rdata_q <= ld_data_d;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_expired) begin
            state_q   <= S_RESP;
            enable_q  <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_MERGE: begin
          state_q  <= S_WR;
          enable_q <= 1'b1;
          rnw_q    <= 1'b0;
          din_q    <= merged_d;
`ifdef LSU_TIMEOUT_EN
          wait_q   <= '0;
`endif
        end
        S_WR: begin
          if (bus.DRAM_READY) begin
            state_q  <= S_RESP;
            enable_q <= 1'b0;
            rnw_q    <= 1'b1;
            done_q   <= 1'b1;
            rdata_q  <= '0;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_expired) begin
            state_q   <= S_RESP;
            enable_q  <= 1'b0;
            rnw_q     <= 1'b1;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            rdata_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q  <= S_IDLE;
          enable_q <= 1'b0;
          rnw_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.DRAM_ENABLE       = enable_q;
  assign bus.DRAM_READNOTWRITE = rnw_q;
  assign bus.DRAM_ADDRESS      = addr_q;
  assign bus.DRAM_IN           = din_q;
  assign bus.rdata             = rdata_q;
  assign bus.done              = done_q;
  assign bus.misalign          = misalign_q;
  assign bus.stall             = bus.req_valid & ~done_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Bench for dram_lsu: directed cases plus random loads/stores against a word-array reference model.
// Memory responder answers after a programmable number of wait cycles.
// Watchdog-abort cases run only when LSU_TIMEOUT_EN is defined.
module tb_dram_lsu;
  import mytypes::*;

  localparam int TO = 8;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  dram_lsu_if #(.NUMBIT(32), .ADDR_SIZE(32)) bus ();

  dram_lsu #(.NUMBIT(32), .ADDR_SIZE(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  int          mem_delay;
  int          pulse_total;
  int          stab_total;
  int          last_gap;
  logic [31:0] last_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: READY after mem_delay wait cycles of ENABLE; logs pulses, gaps, stability
  initial begin : responder
    int          en_cyc;
    int          low_run;
    logic        en_prev;
    logic [5:0]  ridx;
    logic [31:0] win_addr;
    logic [31:0] win_din;
    logic        win_rnw;
    en_cyc = 0; low_run = 0; en_prev = 1'b0;
    win_addr = 0; win_din = 0; win_rnw = 1'b1;
    pulse_total = 0; stab_total = 0; last_gap = 0; last_addr = 0;
    bus.DRAM_READY = 1'b0;
    bus.DRAM_OUT   = 32'h0;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
    dmem[4] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (bus.DRAM_ENABLE === 1'b1) begin
        ridx = bus.DRAM_ADDRESS[7:2];
        if (!en_prev) begin
          pulse_total++;
          last_gap = low_run;
          en_cyc   = 0;
          win_addr = bus.DRAM_ADDRESS;
          win_rnw  = bus.DRAM_READNOTWRITE;
          win_din  = bus.DRAM_IN;
        end else if (bus.DRAM_ADDRESS !== win_addr || bus.DRAM_READNOTWRITE !== win_rnw ||
                     (!win_rnw && bus.DRAM_IN !== win_din)) begin
          stab_total++;
        end
        last_addr = bus.DRAM_ADDRESS;
        if (en_cyc >= mem_delay) begin
          bus.DRAM_READY = 1'b1;
          if (bus.DRAM_READNOTWRITE) bus.DRAM_OUT = dmem[ridx];
          else dmem[ridx] = bus.DRAM_IN;
        end else begin
          bus.DRAM_READY = 1'b0;
        end
        en_cyc++;
        low_run = 0;
        en_prev = 1'b1;
      end else begin
        bus.DRAM_READY = 1'b0;
        low_run++;
        en_prev = 1'b0;
      end
    end
  end

  // One request, predicted from the reference memory and the access rules; delay >= 1000 means memory never answers
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay, input string tag);
    int          sz, lane, idx, exp_lat, exp_pulses, n, p0, s0;
    logic        mis, stuck, seen, stall_ok;
    logic [31:0] w, v, exp_rd, mask, exp_word;
    if (we) sz = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    else    sz = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
    lane  = int'(addr % 4);
    idx   = int'((addr / 4) % 64);
    mis   = (addr % 32'(sz)) != 0;
    stuck = delay >= 1000;
    w      = ref_mem[idx];
    exp_rd = w;
    if (sz == 1) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFFFF00;
      exp_rd = v;
    end else if (sz == 2) begin
      v = (w >> (8 * lane)) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF0000;
      exp_rd = v;
    end
    mask     = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFFFFFF;
    exp_word = (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
    if (mis)                begin exp_lat = 2;             exp_pulses = 0; end
    else if (stuck)         begin exp_lat = 2 + TO;        exp_pulses = 1; end
    else if (we && sz < 4)  begin exp_lat = 5 + 2 * delay; exp_pulses = 2; end
    else                    begin exp_lat = 3 + delay;     exp_pulses = 1; end

    mem_delay = delay;
    p0 = pulse_total;
    s0 = stab_total;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    n = 0; seen = 1'b0; stall_ok = 1'b1;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(n + 1), 32'(exp_lat));
    check({tag, " stall_before_done"}, 32'(stall_ok), 32'd1);
    check({tag, " stall_at_done"}, 32'(bus.stall), 32'd0);
    check({tag, " misalign"}, 32'(bus.misalign), 32'(mis));
    check({tag, " timeout"}, 32'(bus.timeout), 32'(stuck));
    if (!mis && (!we || stuck)) check({tag, " rdata"}, bus.rdata, stuck ? 32'h0 : exp_rd);
    check({tag, " enable_pulses"}, 32'(pulse_total - p0), 32'(exp_pulses));
    if (exp_pulses > 0) begin
      check({tag, " dram_addr"}, last_addr, addr & 32'hFFFFFFFC);
      check({tag, " window_stable"}, 32'(stab_total - s0), 32'd0);
    end
    if (exp_pulses == 2) check({tag, " phase_gap"}, 32'(last_gap), 32'd1);
    if (we && !mis && !stuck) ref_mem[idx] = exp_word;
    if (we) check({tag, " mem_word"}, dmem[idx], ref_mem[idx]);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({tag, " done_one_cycle"}, 32'(bus.done), 32'd0);
  endtask

  initial begin : main
    logic [2:0] ld_f3 [7];
    logic [2:0] st_f3 [4];
    int         nd;
    vectors = 0;
    errors  = 0;
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110};
    st_f3 = '{3'b000, 3'b001, 3'b010, 3'b011};
    rst            = 1'b1;
    mem_delay      = 0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 64; i++) ref_mem[i] = dmem[i];
    ref_mem[4] = 32'hDEADBEEF;

    check("reset rdata", bus.rdata, 32'h0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset misalign", 32'(bus.misalign), 32'd0);
    check("reset timeout", 32'(bus.timeout), 32'd0);
    check("reset enable", 32'(bus.DRAM_ENABLE), 32'd0);
    check("reset rnw", 32'(bus.DRAM_READNOTWRITE), 32'd1);
    check("reset addr", bus.DRAM_ADDRESS, 32'h0);
    check("reset din", bus.DRAM_IN, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    run_req(1'b0, F3_W,  32'h10, 32'h0, 0, "lw_10");
    run_req(1'b0, F3_B,  32'h13, 32'h0, 0, "lb_13");
    run_req(1'b0, F3_BU, 32'h13, 32'h0, 0, "lbu_13");
    run_req(1'b0, F3_H,  32'h12, 32'h0, 0, "lh_12");
    run_req(1'b1, F3_B,  32'h11, 32'h00000055, 0, "sb_11");
    run_req(1'b0, F3_W,  32'h10, 32'h0, 0, "lw_after_sb");
    run_req(1'b0, F3_W,  32'h12, 32'h0, 0, "lw_mis_12");
    run_req(1'b1, F3_H,  32'h13, 32'hCAFEF00D, 0, "sh_mis_13");
    run_req(1'b1, F3_W,  32'h20, 32'h12345678, 4, "sw_20_slow");
    run_req(1'b1, F3_H,  32'h22, 32'h0000ABCD, 2, "sh_22_slow");
    run_req(1'b0, F3_HU, 32'h22, 32'h0, 1, "lhu_22");

    // Reset during the read phase abandons the access without a done pulse
    mem_delay      = 20;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h10;
    @(negedge clk);
    check("rst_mid enable_up", 32'(bus.DRAM_ENABLE), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid enable_dropped", 32'(bus.DRAM_ENABLE), 32'd0);
    check("rst_mid no_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.DRAM_ENABLE === 1'b1) nd++;
    end
    check("rst_mid quiet_after", 32'(nd), 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic        we_r;
      logic [2:0]  f3_r;
      logic [31:0] a_r;
      we_r = 1'($urandom_range(0, 1));
      f3_r = we_r ? st_f3[$urandom_range(0, 3)] : ld_f3[$urandom_range(0, 6)];
      a_r  = 32'($urandom_range(0, 255));
      run_req(we_r, f3_r, a_r, $urandom, int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
    end

`ifdef LSU_TIMEOUT_EN
    run_req(1'b0, F3_B, 32'h10, 32'h0, 1000, "timeout_lb");
    run_req(1'b1, F3_B, 32'h11, 32'h000000AA, 1000, "timeout_sb");
    run_req(1'b1, F3_W, 32'h24, 32'h0BADF00D, 1000, "timeout_sw");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
